// File: rtl/mul_div_pkg.sv
// Shared constants and types for the sequential multiply/divide units of the DLX custom datapath.
package mul_div_pkg;
  localparam int OP_W  = 32;
  localparam int RES_W = 64;
  localparam int CNT_W = 6;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [RES_W-1:0] res_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // 32 shift-add steps plus the completion cycle.
  localparam cnt_t CNT_LOAD = 6'd33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/multiply_if.sv
// start/ready/result handshake shared by the sequential multiplier and divider.
// start launches (and pre-empts) an operation; ready pulses for one cycle with result valid only then.
interface multiply_if;
  import mul_div_pkg::*;

  logic               start;
  logic signed [31:0] opA;
  logic signed [31:0] opB;
  logic               ready;
  logic [63:0]        result;
  state_t             state;

  modport master (output start, opA, opB, input ready, result, state);
  modport slave  (input start, opA, opB, output ready, result, state);
endinterface

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);
  always_comb begin
    count = 6'd32;
    // Ascending scan: the highest set bit is the last one to win.
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end
endmodule

// File: rtl/multiply.sv
// Iterative radix-2 shift-add unsigned multiplier, one multiplier bit per cycle.
// Optional MULTIPLY_EARLY_EXIT_EN skips the multiplier's leading zeros and realigns the product at the end.
module multiply
  import mul_div_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  multiply_if.slave bus
);
  op_t  a, a_nx;
  res_t pb, pb_nx;
  cnt_t cnt, cnt_nx;
  logic [OP_W:0] sum;

`ifdef MULTIPLY_EARLY_EXIT_EN
  cnt_t sh, sh_nx;
  cnt_t lz;

  lzc32 u_lzc (
    .value (op_t'(bus.opB)),
    .count (lz)
  );
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a   <= '0;
      pb  <= '0;
      cnt <= '0;
`ifdef MULTIPLY_EARLY_EXIT_EN
      sh  <= '0;
`endif
    end else begin
      a   <= a_nx;
      pb  <= pb_nx;
      cnt <= cnt_nx;
`ifdef MULTIPLY_EARLY_EXIT_EN
      sh  <= sh_nx;
`endif
    end
  end

  always_comb begin
    a_nx       = a;
    pb_nx      = pb;
    cnt_nx     = cnt;
`ifdef MULTIPLY_EARLY_EXIT_EN
    sh_nx      = sh;
`endif
    bus.ready  = 1'b0;
    bus.result = '0;
    // Carry of the partial-product add lands in sum[OP_W].
    sum        = {1'b0, pb[RES_W-1:OP_W]} + {1'b0, a};

    if (bus.start) begin
      a_nx  = op_t'(bus.opA);
      pb_nx = {{OP_W{1'b0}}, op_t'(bus.opB)};
`ifdef MULTIPLY_EARLY_EXIT_EN
      // w = 32 - lz significant multiplier bits: w steps plus the completion cycle.
      cnt_nx = CNT_LOAD - lz;
      sh_nx  = lz;
`else
      cnt_nx = CNT_LOAD;
`endif
    end else if (cnt > cnt_t'(1)) begin
      if (pb[0]) pb_nx = {sum, pb[OP_W-1:1]};
      else       pb_nx = {1'b0, pb[RES_W-1:1]};
      cnt_nx = cnt - cnt_t'(1);
    end else if (cnt == cnt_t'(1)) begin
      bus.ready  = 1'b1;
`ifdef MULTIPLY_EARLY_EXIT_EN
      // After w steps the product sits lz bits too high in PB.
      bus.result = pb >> sh;
`else
      bus.result = pb;
`endif
      cnt_nx = '0;
    end
  end

  always_comb begin
    if (cnt == '0)                bus.state = ST_IDLE;
    else if (cnt == cnt_t'(1))    bus.state = ST_DONE;
    else                          bus.state = ST_BUSY;
  end
endmodule
